// File: rtl/aidc_path_switch.sv
`default_nettype none
// ============================================================================
//  Module      : aidc_path_switch
//  Description : Routes one request/response channel pair either straight to
//                the XHB (mode 0) or through the AIDC compress/decompress loop
//                (mode 1). Every hop ends in a one-entry register slice.
//                A mode change waits until nothing is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module aidc_path_switch #(
    parameter int DATA_W  = 32,
    parameter int OUTST_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              enable_i,
    output logic              mode_o,
    output logic              switch_pending_o,
    output logic [OUTST_W-1:0] outst_o,

    input  logic              src_req_valid_i,
    output logic              src_req_ready_o,
    input  logic [DATA_W-1:0] src_req_data_i,

    output logic              aidc_req_valid_o,
    input  logic              aidc_req_ready_i,
    output logic [DATA_W-1:0] aidc_req_data_o,

    input  logic              caidc_req_valid_i,
    output logic              caidc_req_ready_o,
    input  logic [DATA_W-1:0] caidc_req_data_i,

    output logic              xhb_req_valid_o,
    input  logic              xhb_req_ready_i,
    output logic [DATA_W-1:0] xhb_req_data_o,

    input  logic              xhb_rsp_valid_i,
    output logic              xhb_rsp_ready_o,
    input  logic [DATA_W-1:0] xhb_rsp_data_i,

    output logic              aidc_rsp_valid_o,
    input  logic              aidc_rsp_ready_i,
    output logic [DATA_W-1:0] aidc_rsp_data_o,

    input  logic              daidc_rsp_valid_i,
    output logic              daidc_rsp_ready_o,
    input  logic [DATA_W-1:0] daidc_rsp_data_i,

    output logic              src_rsp_valid_o,
    input  logic              src_rsp_ready_i,
    output logic [DATA_W-1:0] src_rsp_data_o
);

    // Slice indices
    localparam int NSLICE      = 4;
    localparam int SL_XHB_REQ  = 0;
    localparam int SL_AIDC_REQ = 1;
    localparam int SL_AIDC_RSP = 2;
    localparam int SL_SRC_RSP  = 3;

    localparam logic [OUTST_W-1:0] OUTST_MAX = '1;
    localparam logic [OUTST_W-1:0] OUTST_ONE = {{(OUTST_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [OUTST_W-1:0]  outst_q, outst_d;

    logic [NSLICE-1:0]   sl_valid_q, sl_valid_d;
    logic [DATA_W-1:0]   sl_data_q  [NSLICE];
    logic [DATA_W-1:0]   sl_data_d  [NSLICE];
    logic [NSLICE-1:0]   sl_in_valid;
    logic [DATA_W-1:0]   sl_in_data [NSLICE];
    logic [NSLICE-1:0]   sl_out_ready;
    logic [NSLICE-1:0]   sl_in_ready;
    logic [NSLICE-1:0]   sl_load;

    logic                src_req_fire;
    logic                src_rsp_fire;
    logic                all_empty;

    // Downstream readiness of each slice and the resulting upstream readiness
    assign sl_out_ready[SL_XHB_REQ]  = xhb_req_ready_i;
    assign sl_out_ready[SL_AIDC_REQ] = aidc_req_ready_i;
    assign sl_out_ready[SL_AIDC_RSP] = aidc_rsp_ready_i;
    assign sl_out_ready[SL_SRC_RSP]  = src_rsp_ready_i;
    assign sl_in_ready               = ~sl_valid_q | sl_out_ready;
    assign sl_load                   = sl_in_valid & sl_in_ready;

    // New requests are only taken in ACTIVE and while the counter has headroom
    assign src_req_ready_o   = (state_q == ST_ACTIVE) && (outst_q != OUTST_MAX) &&
                               (mode_q ? sl_in_ready[SL_AIDC_REQ] : sl_in_ready[SL_XHB_REQ]);
    assign caidc_req_ready_o = mode_q && sl_in_ready[SL_XHB_REQ];
    assign xhb_rsp_ready_o   = mode_q ? sl_in_ready[SL_AIDC_RSP] : sl_in_ready[SL_SRC_RSP];
    assign daidc_rsp_ready_o = mode_q && sl_in_ready[SL_SRC_RSP];

    assign src_req_fire = src_req_valid_i && src_req_ready_o;
    assign src_rsp_fire = sl_valid_q[SL_SRC_RSP] && src_rsp_ready_i;
    assign all_empty    = ~|sl_valid_q;

    // Select the source feeding each slice according to the active mode
    always_comb begin
        sl_in_valid              = '0;
        sl_in_data[SL_XHB_REQ]   = mode_q ? caidc_req_data_i : src_req_data_i;
        sl_in_data[SL_AIDC_REQ]  = src_req_data_i;
        sl_in_data[SL_AIDC_RSP]  = xhb_rsp_data_i;
        sl_in_data[SL_SRC_RSP]   = mode_q ? daidc_rsp_data_i : xhb_rsp_data_i;
        sl_in_valid[SL_XHB_REQ]  = mode_q ? caidc_req_valid_i : src_req_fire;
        sl_in_valid[SL_AIDC_REQ] = mode_q && src_req_fire;
        sl_in_valid[SL_AIDC_RSP] = mode_q && xhb_rsp_valid_i;
        sl_in_valid[SL_SRC_RSP]  = mode_q ? daidc_rsp_valid_i : xhb_rsp_valid_i;
    end

    // Slice next state: load on accept, otherwise empty once the consumer takes it
    always_comb begin
        sl_valid_d = sl_valid_q;
        for (int i = 0; i < NSLICE; i++) begin
            sl_data_d[i]  = sl_load[i] ? sl_in_data[i] : sl_data_q[i];
            sl_valid_d[i] = sl_load[i] | (sl_valid_q[i] & ~sl_out_ready[i]);
        end
    end

    // Outstanding count: a simultaneous accept and retire leaves it unchanged
    always_comb begin
        outst_d = outst_q;
        case ({src_req_fire, src_rsp_fire})
            2'b10:   outst_d = outst_q + OUTST_ONE;
            2'b01:   outst_d = outst_q - OUTST_ONE;
            default: outst_d = outst_q;
        endcase
    end

    // Mode-change FSM: drain everything in flight before flipping the path
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            ST_ACTIVE: begin
                if (enable_i != mode_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable_i == mode_q)
                    state_d = ST_ACTIVE;
                else if ((outst_q == '0) && all_empty)
                    state_d = ST_SWITCH;
            end
            ST_SWITCH: begin
                mode_d  = ~mode_q;
                state_d = ST_ACTIVE;
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    // State, mode, counter and slice registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACTIVE;
            mode_q     <= 1'b0;
            outst_q    <= '0;
            sl_valid_q <= '0;
            for (int i = 0; i < NSLICE; i++) sl_data_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            outst_q    <= outst_d;
            sl_valid_q <= sl_valid_d;
            for (int i = 0; i < NSLICE; i++) sl_data_q[i] <= sl_data_d[i];
        end
    end

    assign mode_o           = mode_q;
    assign switch_pending_o = (state_q != ST_ACTIVE);
    assign outst_o          = outst_q;

    assign xhb_req_valid_o  = sl_valid_q[SL_XHB_REQ];
    assign xhb_req_data_o   = sl_data_q[SL_XHB_REQ];
    assign aidc_req_valid_o = sl_valid_q[SL_AIDC_REQ];
    assign aidc_req_data_o  = sl_data_q[SL_AIDC_REQ];
    assign aidc_rsp_valid_o = sl_valid_q[SL_AIDC_RSP];
    assign aidc_rsp_data_o  = sl_data_q[SL_AIDC_RSP];
    assign src_rsp_valid_o  = sl_valid_q[SL_SRC_RSP];
    assign src_rsp_data_o   = sl_data_q[SL_SRC_RSP];

endmodule
`default_nettype wire

// File: tb/tb_aidc_path_switch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aidc_path_switch
//  Description : Self-checking bench for aidc_path_switch. Directed scenarios
//                plus randomized traffic scored against transaction queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aidc_path_switch;

    localparam int DATA_W  = 32;
    localparam int OUTST_W = 4;
    localparam int MAXO    = (1 << OUTST_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable_i = 1'b0;
    logic mode_o, switch_pending_o;
    logic [OUTST_W-1:0] outst_o;
    logic src_req_valid_i = 0, src_req_ready_o;      logic [DATA_W-1:0] src_req_data_i = '0;
    logic aidc_req_valid_o, aidc_req_ready_i = 0;    logic [DATA_W-1:0] aidc_req_data_o;
    logic caidc_req_valid_i = 0, caidc_req_ready_o;  logic [DATA_W-1:0] caidc_req_data_i = '0;
    logic xhb_req_valid_o, xhb_req_ready_i = 0;      logic [DATA_W-1:0] xhb_req_data_o;
    logic xhb_rsp_valid_i = 0, xhb_rsp_ready_o;      logic [DATA_W-1:0] xhb_rsp_data_i = '0;
    logic aidc_rsp_valid_o, aidc_rsp_ready_i = 0;    logic [DATA_W-1:0] aidc_rsp_data_o;
    logic daidc_rsp_valid_i = 0, daidc_rsp_ready_o;  logic [DATA_W-1:0] daidc_rsp_data_i = '0;
    logic src_rsp_valid_o, src_rsp_ready_i = 0;      logic [DATA_W-1:0] src_rsp_data_o;

    int n_cmp  = 0;
    int n_fail = 0;

    aidc_path_switch #(.DATA_W(DATA_W), .OUTST_W(OUTST_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
        .mode_o(mode_o), .switch_pending_o(switch_pending_o), .outst_o(outst_o),
        .src_req_valid_i(src_req_valid_i), .src_req_ready_o(src_req_ready_o), .src_req_data_i(src_req_data_i),
        .aidc_req_valid_o(aidc_req_valid_o), .aidc_req_ready_i(aidc_req_ready_i), .aidc_req_data_o(aidc_req_data_o),
        .caidc_req_valid_i(caidc_req_valid_i), .caidc_req_ready_o(caidc_req_ready_o), .caidc_req_data_i(caidc_req_data_i),
        .xhb_req_valid_o(xhb_req_valid_o), .xhb_req_ready_i(xhb_req_ready_i), .xhb_req_data_o(xhb_req_data_o),
        .xhb_rsp_valid_i(xhb_rsp_valid_i), .xhb_rsp_ready_o(xhb_rsp_ready_o), .xhb_rsp_data_i(xhb_rsp_data_i),
        .aidc_rsp_valid_o(aidc_rsp_valid_o), .aidc_rsp_ready_i(aidc_rsp_ready_i), .aidc_rsp_data_o(aidc_rsp_data_o),
        .daidc_rsp_valid_i(daidc_rsp_valid_i), .daidc_rsp_ready_o(daidc_rsp_ready_o), .daidc_rsp_data_i(daidc_rsp_data_i),
        .src_rsp_valid_o(src_rsp_valid_o), .src_rsp_ready_i(src_rsp_ready_i), .src_rsp_data_o(src_rsp_data_o)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic clear_inputs();
        src_req_valid_i = 0; src_req_data_i = '0;
        aidc_req_ready_i = 0;
        caidc_req_valid_i = 0; caidc_req_data_i = '0;
        xhb_req_ready_i = 0;
        xhb_rsp_valid_i = 0; xhb_rsp_data_i = '0;
        aidc_rsp_ready_i = 0;
        daidc_rsp_valid_i = 0; daidc_rsp_data_i = '0;
        src_rsp_ready_i = 0;
    endtask

    // Leaves the bench at a falling edge with reset just released
    task automatic do_reset(input logic en);
        clear_inputs();
        enable_i = en;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Accept n requests from the bench side, one per cycle
    task automatic send_reqs(input int n, input logic [DATA_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            src_req_valid_i = 1; src_req_data_i = base + DATA_W'(i);
            @(negedge clk);
        end
        src_req_valid_i = 0;
    endtask

    task automatic test_reset();
        do_reset(0);
        n_cmp++; if (mode_o !== 1'b0) begin n_fail++; $display("FAIL reset_mode: got %b want 0", mode_o); end
        n_cmp++; if (switch_pending_o !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", switch_pending_o); end
        n_cmp++; if (outst_o !== '0) begin n_fail++; $display("FAIL reset_outst: got %0d want 0", outst_o); end
        n_cmp++;
        if ({xhb_req_valid_o, aidc_req_valid_o, aidc_rsp_valid_o, src_rsp_valid_o} !== 4'b0) begin
            n_fail++; $display("FAIL reset_valids: got %b want 0000",
                {xhb_req_valid_o, aidc_req_valid_o, aidc_rsp_valid_o, src_rsp_valid_o});
        end
    endtask

    task automatic test_bypass_stream();
        do_reset(0);
        xhb_req_ready_i = 1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                n_cmp++;
                if (xhb_req_valid_o !== 1'b1 || xhb_req_data_o !== DATA_W'(32'h10 + i - 1)) begin
                    n_fail++; $display("FAIL bypass_data[%0d]: got v=%b d=%08h want v=1 d=%08h",
                        i - 1, xhb_req_valid_o, xhb_req_data_o, 32'h10 + i - 1);
                end
            end
            n_cmp++; if (aidc_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL bypass_aidc_valid: got %b want 0", aidc_req_valid_o); end
            src_req_valid_i = (i < 8);
            src_req_data_i  = DATA_W'(32'h10 + i);
            #1;
            if (i < 8) begin
                n_cmp++; if (src_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL bypass_ready[%0d]: got %b want 1", i, src_req_ready_o); end
            end
            @(negedge clk);
        end
        n_cmp++; if (outst_o !== 4'd8) begin n_fail++; $display("FAIL bypass_outst: got %0d want 8", outst_o); end
    endtask

    task automatic test_aidc_loop();
        logic [2:0] exp_mode;
        logic [2:0] exp_pend;
        exp_mode = 3'b100;
        exp_pend = 3'b011;
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (mode_o !== exp_mode[k] || switch_pending_o !== exp_pend[k]) begin
                n_fail++; $display("FAIL loop_switch_cyc%0d: got mode=%b pend=%b want mode=%b pend=%b",
                    k + 1, mode_o, switch_pending_o, exp_mode[k], exp_pend[k]);
            end
        end
        aidc_req_ready_i = 1; xhb_req_ready_i = 1; aidc_rsp_ready_i = 1; src_rsp_ready_i = 1;
        src_req_valid_i = 1; src_req_data_i = 32'hA5;
        @(negedge clk);
        src_req_valid_i = 0;
        n_cmp++; if (aidc_req_valid_o !== 1'b1 || aidc_req_data_o !== 32'hA5) begin n_fail++; $display("FAIL loop_aidc_req: got v=%b d=%08h want v=1 d=000000a5", aidc_req_valid_o, aidc_req_data_o); end
        n_cmp++; if (outst_o !== 4'd1) begin n_fail++; $display("FAIL loop_outst1: got %0d want 1", outst_o); end
        caidc_req_valid_i = 1; caidc_req_data_i = 32'h5A;
        @(negedge clk);
        caidc_req_valid_i = 0;
        n_cmp++; if (xhb_req_valid_o !== 1'b1 || xhb_req_data_o !== 32'h5A) begin n_fail++; $display("FAIL loop_xhb_req: got v=%b d=%08h want v=1 d=0000005a", xhb_req_valid_o, xhb_req_data_o); end
        xhb_rsp_valid_i = 1; xhb_rsp_data_i = 32'h33;
        @(negedge clk);
        xhb_rsp_valid_i = 0;
        n_cmp++; if (aidc_rsp_valid_o !== 1'b1 || aidc_rsp_data_o !== 32'h33) begin n_fail++; $display("FAIL loop_aidc_rsp: got v=%b d=%08h want v=1 d=00000033", aidc_rsp_valid_o, aidc_rsp_data_o); end
        daidc_rsp_valid_i = 1; daidc_rsp_data_i = 32'hCC;
        @(negedge clk);
        daidc_rsp_valid_i = 0;
        n_cmp++; if (src_rsp_valid_o !== 1'b1 || src_rsp_data_o !== 32'hCC) begin n_fail++; $display("FAIL loop_src_rsp: got v=%b d=%08h want v=1 d=000000cc", src_rsp_valid_o, src_rsp_data_o); end
        @(negedge clk);
        n_cmp++; if (outst_o !== 4'd0) begin n_fail++; $display("FAIL loop_outst0: got %0d want 0", outst_o); end
    endtask

    task automatic test_deferred_switch();
        int sent, got;
        do_reset(0);
        xhb_req_ready_i = 1;
        send_reqs(3, 32'h40);
        n_cmp++; if (outst_o !== 4'd3) begin n_fail++; $display("FAIL defer_outst: got %0d want 3", outst_o); end
        enable_i = 1;
        @(negedge clk);
        src_req_valid_i = 1; src_req_data_i = 32'hDEAD;
        #1;
        n_cmp++; if (switch_pending_o !== 1'b1 || src_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL defer_enter: got pend=%b rdy=%b want pend=1 rdy=0", switch_pending_o, src_req_ready_o); end
        sent = 0; got = 0;
        src_rsp_ready_i = 1;
        for (int c = 0; c < 40 && got < 3; c++) begin
            xhb_rsp_valid_i = (sent < 3); xhb_rsp_data_i = DATA_W'(32'h100 + sent);
            #1;
            n_cmp++; if (mode_o !== 1'b0 || src_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL defer_hold: got mode=%b rdy=%b want mode=0 rdy=0", mode_o, src_req_ready_o); end
            if (xhb_rsp_valid_i && xhb_rsp_ready_o) sent++;
            if (src_rsp_valid_o && src_rsp_ready_i) got++;
            @(negedge clk);
        end
        xhb_rsp_valid_i = 0;
        n_cmp++; if (got != 3) begin n_fail++; $display("FAIL defer_rsp_count: got %0d want 3", got); end
        n_cmp++; if (mode_o !== 1'b0 || switch_pending_o !== 1'b1 || outst_o !== '0) begin n_fail++; $display("FAIL defer_n0: got mode=%b pend=%b outst=%0d want 0/1/0", mode_o, switch_pending_o, outst_o); end
        @(negedge clk);
        n_cmp++; if (mode_o !== 1'b0) begin n_fail++; $display("FAIL defer_n1: got mode=%b want 0", mode_o); end
        @(negedge clk);
        n_cmp++; if (mode_o !== 1'b1 || switch_pending_o !== 1'b0 || src_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL defer_n2: got mode=%b pend=%b rdy=%b want 1/0/1", mode_o, switch_pending_o, src_req_ready_o); end
        src_req_valid_i = 0;
    endtask

    task automatic test_aborted_switch();
        do_reset(0);
        xhb_req_ready_i = 1;
        send_reqs(2, 32'h50);
        enable_i = 1;
        @(negedge clk);
        enable_i = 0;
        n_cmp++; if (switch_pending_o !== 1'b1 || src_req_ready_o !== 1'b0 || mode_o !== 1'b0) begin n_fail++; $display("FAIL abort_drain: got pend=%b rdy=%b mode=%b want 1/0/0", switch_pending_o, src_req_ready_o, mode_o); end
        @(negedge clk);
        n_cmp++; if (switch_pending_o !== 1'b0 || mode_o !== 1'b0) begin n_fail++; $display("FAIL abort_back: got pend=%b mode=%b want 0/0", switch_pending_o, mode_o); end
        src_req_valid_i = 1; src_req_data_i = 32'h52;
        #1;
        n_cmp++; if (src_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL abort_resume: got %b want 1", src_req_ready_o); end
        @(negedge clk);
        src_req_valid_i = 0;
        n_cmp++; if (outst_o !== 4'd3 || mode_o !== 1'b0) begin n_fail++; $display("FAIL abort_outst: got outst=%0d mode=%b want 3/0", outst_o, mode_o); end
    endtask

    task automatic test_saturation_backpressure();
        int acc;
        do_reset(0);
        xhb_req_ready_i = 1;
        acc = 0;
        for (int c = 0; c < MAXO + 5; c++) begin
            src_req_valid_i = 1; src_req_data_i = DATA_W'(c);
            #1;
            if (src_req_ready_o) acc++;
            @(negedge clk);
        end
        #1;
        n_cmp++; if (acc != MAXO || outst_o !== OUTST_W'(MAXO) || src_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL sat: got acc=%0d outst=%0d rdy=%b want %0d/%0d/0", acc, outst_o, src_req_ready_o, MAXO, MAXO); end
        // Stalled XHB: the slice must hold its word
        do_reset(0);
        src_req_valid_i = 1; src_req_data_i = 32'h77;
        @(negedge clk);
        src_req_data_i = 32'h88;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (xhb_req_valid_o !== 1'b1 || xhb_req_data_o !== 32'h77 || src_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%08h rdy=%b want 1/00000077/0", k, xhb_req_valid_o, xhb_req_data_o, src_req_ready_o); end
            @(negedge clk);
        end
        xhb_req_ready_i = 1;
        #1;
        n_cmp++; if (src_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", src_req_ready_o); end
        @(negedge clk);
        n_cmp++; if (xhb_req_data_o !== 32'h88) begin n_fail++; $display("FAIL bp_next: got %08h want 00000088", xhb_req_data_o); end
        src_req_data_i = 32'h99;
        @(negedge clk);
        src_req_valid_i = 0;
        // Park one response in the src_rsp slice, then retire it while accepting
        xhb_rsp_valid_i = 1; xhb_rsp_data_i = 32'hAB;
        @(negedge clk);
        xhb_rsp_valid_i = 0;
        n_cmp++; if (outst_o !== 4'd3 || src_rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL simul_pre: got outst=%0d v=%b want 3/1", outst_o, src_rsp_valid_o); end
        src_req_valid_i = 1; src_req_data_i = 32'hAC; src_rsp_ready_i = 1;
        #1;
        n_cmp++; if (src_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL simul_rdy: got %b want 1", src_req_ready_o); end
        @(negedge clk);
        src_req_valid_i = 0; src_rsp_ready_i = 0;
        n_cmp++; if (outst_o !== 4'd3) begin n_fail++; $display("FAIL simul_outst: got %0d want 3", outst_o); end
    endtask

    task automatic test_async_reset();
        do_reset(1);
        repeat (3) @(negedge clk);
        aidc_req_ready_i = 1;
        send_reqs(5, 32'h60);
        aidc_req_ready_i = 0;
        caidc_req_valid_i = 1; caidc_req_data_i = 32'h61;
        xhb_rsp_valid_i = 1;   xhb_rsp_data_i = 32'h62;
        daidc_rsp_valid_i = 1; daidc_rsp_data_i = 32'h63;
        @(negedge clk);
        caidc_req_valid_i = 0; xhb_rsp_valid_i = 0; daidc_rsp_valid_i = 0;
        n_cmp++;
        if ({xhb_req_valid_o, aidc_req_valid_o, aidc_rsp_valid_o, src_rsp_valid_o} !== 4'b1111 || outst_o !== 4'd5 || mode_o !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got v=%b outst=%0d mode=%b want 1111/5/1",
                {xhb_req_valid_o, aidc_req_valid_o, aidc_rsp_valid_o, src_rsp_valid_o}, outst_o, mode_o);
        end
        #2;
        rst_n = 0;
        #1;
        n_cmp++;
        if ({xhb_req_valid_o, aidc_req_valid_o, aidc_rsp_valid_o, src_rsp_valid_o} !== 4'b0 || outst_o !== '0 || mode_o !== 1'b0 || switch_pending_o !== 1'b0) begin
            n_fail++; $display("FAIL areset_post: got v=%b outst=%0d mode=%b pend=%b want 0000/0/0/0",
                {xhb_req_valid_o, aidc_req_valid_o, aidc_rsp_valid_o, src_rsp_valid_o}, outst_o, mode_o, switch_pending_o);
        end
        enable_i = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    // Random traffic on a fixed mode; the bench plays CNN engine, AIDC and XHB
    task automatic test_random_traffic(input logic m, input int n_cycles);
        logic [DATA_W-1:0] q_aidc_req[$], q_xhb_req[$], q_aidc_rsp[$], q_src_rsp[$];
        logic [DATA_W-1:0] p_caidc[$], p_xhb[$], p_daidc[$];
        logic [DATA_W-1:0] exp;
        int cnt;
        logic allow;
        cnt = 0;
        do_reset(m);
        if (m) repeat (3) @(negedge clk);
        for (int c = 0; c < n_cycles + 300; c++) begin
            allow = (c < n_cycles);
            if (!allow && cnt == 0 && p_caidc.size() == 0 && p_xhb.size() == 0 && p_daidc.size() == 0 &&
                q_xhb_req.size() == 0 && q_aidc_req.size() == 0 && q_aidc_rsp.size() == 0 && q_src_rsp.size() == 0)
                break;
            src_req_valid_i  = allow && ($urandom_range(0, 3) != 0);
            src_req_data_i   = $urandom;
            aidc_req_ready_i = ($urandom_range(0, 3) != 0);
            xhb_req_ready_i  = ($urandom_range(0, 3) != 0);
            aidc_rsp_ready_i = ($urandom_range(0, 3) != 0);
            src_rsp_ready_i  = ($urandom_range(0, 3) != 0);
            caidc_req_valid_i = m ? (p_caidc.size() > 0 && $urandom_range(0, 2) != 0) : ($urandom_range(0, 1) == 1);
            caidc_req_data_i  = (m && p_caidc.size() > 0) ? p_caidc[0] : $urandom;
            xhb_rsp_valid_i   = (p_xhb.size() > 0 && $urandom_range(0, 2) != 0);
            xhb_rsp_data_i    = (p_xhb.size() > 0) ? p_xhb[0] : $urandom;
            daidc_rsp_valid_i = m ? (p_daidc.size() > 0 && $urandom_range(0, 2) != 0) : ($urandom_range(0, 1) == 1);
            daidc_rsp_data_i  = (m && p_daidc.size() > 0) ? p_daidc[0] : $urandom;
            #1;
            n_cmp++; if (outst_o !== OUTST_W'(cnt) || mode_o !== m) begin n_fail++; $display("FAIL rnd%0d_state: got outst=%0d mode=%b want %0d/%b", m, outst_o, mode_o, cnt, m); end
            if (!m) begin
                n_cmp++;
                if ({aidc_req_valid_o, aidc_rsp_valid_o, caidc_req_ready_o, daidc_rsp_ready_o} !== 4'b0) begin
                    n_fail++; $display("FAIL rnd0_inactive: got %b want 0000", {aidc_req_valid_o, aidc_rsp_valid_o, caidc_req_ready_o, daidc_rsp_ready_o});
                end
            end
            if (cnt == MAXO) begin
                n_cmp++; if (src_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_max: got rdy=%b want 0", m, src_req_ready_o); end
            end
            // Outputs leaving the DUT, compared against the in-order expectation
            if (aidc_req_valid_o && aidc_req_ready_i) begin
                exp = (q_aidc_req.size() > 0) ? q_aidc_req[0] : ~aidc_req_data_o;
                n_cmp++; if (aidc_req_data_o !== exp) begin n_fail++; $display("FAIL rnd%0d_aidc_req: got %08h want %08h", m, aidc_req_data_o, exp); end
                if (q_aidc_req.size() > 0) void'(q_aidc_req.pop_front());
                p_caidc.push_back(~aidc_req_data_o);
            end
            if (xhb_req_valid_o && xhb_req_ready_i) begin
                exp = (q_xhb_req.size() > 0) ? q_xhb_req[0] : ~xhb_req_data_o;
                n_cmp++; if (xhb_req_data_o !== exp) begin n_fail++; $display("FAIL rnd%0d_xhb_req: got %08h want %08h", m, xhb_req_data_o, exp); end
                if (q_xhb_req.size() > 0) void'(q_xhb_req.pop_front());
                p_xhb.push_back($urandom);
            end
            if (aidc_rsp_valid_o && aidc_rsp_ready_i) begin
                exp = (q_aidc_rsp.size() > 0) ? q_aidc_rsp[0] : ~aidc_rsp_data_o;
                n_cmp++; if (aidc_rsp_data_o !== exp) begin n_fail++; $display("FAIL rnd%0d_aidc_rsp: got %08h want %08h", m, aidc_rsp_data_o, exp); end
                if (q_aidc_rsp.size() > 0) void'(q_aidc_rsp.pop_front());
                p_daidc.push_back(aidc_rsp_data_o ^ 32'h5A5A_5A5A);
            end
            if (src_rsp_valid_o && src_rsp_ready_i) begin
                exp = (q_src_rsp.size() > 0) ? q_src_rsp[0] : ~src_rsp_data_o;
                n_cmp++; if (src_rsp_data_o !== exp) begin n_fail++; $display("FAIL rnd%0d_src_rsp: got %08h want %08h", m, src_rsp_data_o, exp); end
                if (q_src_rsp.size() > 0) void'(q_src_rsp.pop_front());
                cnt--;
            end
            // Inputs accepted by the DUT this cycle
            if (src_req_valid_i && src_req_ready_o) begin
                cnt++;
                if (m) q_aidc_req.push_back(src_req_data_i);
                else   q_xhb_req.push_back(src_req_data_i);
            end
            if (m && caidc_req_valid_i && caidc_req_ready_o) begin
                q_xhb_req.push_back(p_caidc.pop_front());
            end
            if (xhb_rsp_valid_i && xhb_rsp_ready_o) begin
                if (m) q_aidc_rsp.push_back(p_xhb.pop_front());
                else   q_src_rsp.push_back(p_xhb.pop_front());
            end
            if (m && daidc_rsp_valid_i && daidc_rsp_ready_o) begin
                q_src_rsp.push_back(p_daidc.pop_front());
            end
            @(negedge clk);
        end
        clear_inputs();
        n_cmp++;
        if (cnt != 0 || outst_o !== '0 || q_src_rsp.size() != 0 || q_xhb_req.size() != 0 || p_xhb.size() != 0) begin
            n_fail++; $display("FAIL rnd%0d_drain: got cnt=%0d outst=%0d want 0/0", m, cnt, outst_o);
        end
    endtask

    initial begin
        test_reset();
        test_bypass_stream();
        test_aidc_loop();
        test_deferred_switch();
        test_aborted_switch();
        test_saturation_backpressure();
        test_async_reset();
        test_random_traffic(1'b0, 400);
        test_random_traffic(1'b1, 400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
